param_register_file_sb: RTL and testbench
=========================================

Name: param_register_file_sb

Overview:
- Parametrised successor to the 32x32 two-read/one-write register file for the single-cycle and pipelined CPU datapaths.
- Adds asynchronous reset to the known init pattern and an optional hardwired zero register.
- Adds optional write-to-read bypass so the register file can sit in the decode stage of the pipeline.
- Adds a per-register pending scoreboard so the hazard unit can stall on registers with an outstanding multi-cycle writeback, e.g. loads.

Parameters:
- data_width, 32, width of each register in bits.
- select_width, 5, address width; depth = 2**select_width. Derived depth is a localparam, never overridden.
- init_step, 10, register i is loaded with init_step*i, truncated to data_width, at reset.
- zero_reg, 1, when 1 register 0 always reads 0, ignores writes and is never marked pending.
- bypass, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- write_data  input  data_width  data for the write port.
- write_address  input  select_width  write port address.
- RegWrite  input  1  write enable, sampled at posedge clk.
- read_sel_1  input  select_width  read port 1 address.
- read_sel_2  input  select_width  read port 2 address.
- read_data_1  output  data_width  read port 1 data (combinational).
- read_data_2  output  data_width  read port 2 data (combinational).
- busy_set  input  1  marks busy_address pending at posedge clk.
- busy_address  input  select_width  register being claimed by an in-flight producer.
- read_busy_1  output  1  read_sel_1 target is pending.
- read_busy_2  output  1  read_sel_2 target is pending.
- pending_any  output  1  OR of all pending bits (registered state only).

Behaviour:
- Reset:
  - rst_n low asynchronously sets register[i] = init_step*i mod 2**data_width for all i.
  - It also clears all pending bits.
  - Reads are combinational, so read_data_x shows the init values while rst_n is low. read_busy_x = 0 and pending_any = 0 during reset.
  - Reset deasserting mid-sequence needs no recovery state; the first posedge after rst_n rises is a normal cycle.
- Write:
  - At posedge clk, if RegWrite=1 and not (zero_reg=1 and write_address=0), then register[write_address] <= write_data.
  - Otherwise no change.
- Read:
  - read_data_x = register[read_sel_x].
  - Exceptions, in priority order:
    - zero_reg=1 and read_sel_x=0: output 0.
    - bypass=1, RegWrite=1, write_address=read_sel_x and the write is not suppressed: output write_data (same cycle, zero latency).
  - With bypass=0, new data appears the cycle after the write edge.
- Scoreboard, one pending bit per register:
  - Set at posedge when busy_set=1, except busy_address=0 when zero_reg=1.
  - Cleared at posedge when an accepted write targets that address.
  - Simultaneous set and clear of the same address: set wins, because the new producer supersedes the old one and the bit stays 1.
  - Set and clear of different addresses in the same cycle: both take effect.
  - A write to a non-pending register is legal and leaves its bit at 0.
  - busy_set on an already-pending register keeps it at 1; there is no counting and no error.
- read_busy_x:
  - Equals pending[read_sel_x], forced 0 when zero_reg=1 and read_sel_x=0.
  - Also forced 0 when bypass=1 and an accepted write hits read_sel_x this cycle, because the data is being forwarded.
- pending_any reflects registered pending bits only; it is not bypass-adjusted.
- Both read ports are fully independent and may address the same register.

Test Plan:
- Reset values:
  - Assert rst_n=0 asynchronously with no clock edge, then read sel 0..31 -> read_data = 0,10,...,310.
  - read_busy = 0 and pending_any = 0.
- Basic write:
  - RegWrite=1, write_address=5, write_data=0xDEADBEEF with bypass=0 -> same cycle read_sel_1=5 returns 50; after the edge it returns 0xDEADBEEF.
  - With bypass=1 the same stimulus returns 0xDEADBEEF in the same cycle.
- Zero register: write 0x1234 to address 0 -> read_data stays 0 and pending[0] is never set, even with busy_set on address 0.
  - Repeat with zero_reg=0 -> reads 0x1234.
- Scoreboard:
  - busy_set addr 7 -> next cycle read_busy_1=1 (sel 7) and pending_any=1.
  - Write addr 7 with bypass=1 -> read_busy_1=0 in that cycle; after the edge pending_any=0.
  - Simultaneous busy_set and write on addr 9 -> pending[9]=1 after the edge, and register 9 holds the written data.
- Mid-operation reset:
  - With pending 3 and 12 set and register 4 = 0xFFFF, pulse rst_n low between edges -> immediately register 4 reads 40 and pending_any=0.
- Parameter sweep:
  - data_width=8, select_width=3, init_step=50 -> register 6 resets to 300 mod 256 = 44.
  - Address 7 is writable and readable on both ports simultaneously.

Source files
------------

// File: rtl/param_register_file_sb.sv
// Parametrised two-read/one-write register file with known reset pattern, optional
// hardwired zero register, optional write-to-read bypass and a per-register pending scoreboard.
module param_register_file_sb #(
  parameter int data_width   = 32,
  parameter int select_width = 5,
  parameter int init_step    = 10,
  parameter int zero_reg     = 1,
  parameter int bypass       = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [data_width-1:0]   write_data,
  input  logic [select_width-1:0] write_address,
  input  logic                    RegWrite,
  input  logic [select_width-1:0] read_sel_1,
  input  logic [select_width-1:0] read_sel_2,
  output logic [data_width-1:0]   read_data_1,
  output logic [data_width-1:0]   read_data_2,
  input  logic                    busy_set,
  input  logic [select_width-1:0] busy_address,
  output logic                    read_busy_1,
  output logic                    read_busy_2,
  output logic                    pending_any
);

  localparam int depth = 2**select_width;

  logic [data_width-1:0] reg_value [depth];
  logic [depth-1:0]      pending_bits;
  logic                  write_ok;
  logic                  busy_ok;

  // Writes are gated by rst_n so the bypass path cannot mask init values during reset.
  assign write_ok = RegWrite && rst_n && !((zero_reg != 0) && (write_address == '0));
  assign busy_ok  = busy_set && !((zero_reg != 0) && (busy_address == '0));

  generate
    for (genvar gi = 0; gi < depth; gi++) begin : g_reg
      localparam logic [select_width-1:0] addr     = select_width'(gi);
      localparam logic [data_width-1:0]   init_val = data_width'(init_step * gi);

      logic [data_width-1:0] value_reg;
      logic                  pending_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          value_reg   <= init_val;
          pending_reg <= 1'b0;
        end else begin
          if (write_ok && (write_address == addr)) value_reg <= write_data;
          // A new producer claiming the register supersedes the completing one.
          if (busy_ok && (busy_address == addr))
            pending_reg <= 1'b1;
          else if (write_ok && (write_address == addr))
            pending_reg <= 1'b0;
        end
      end

      assign reg_value[gi]    = value_reg;
      assign pending_bits[gi] = pending_reg;
    end
  endgenerate

  always_comb begin
    read_data_1 = reg_value[read_sel_1];
    read_busy_1 = pending_bits[read_sel_1];
    read_data_2 = reg_value[read_sel_2];
    read_busy_2 = pending_bits[read_sel_2];

    if ((bypass != 0) && write_ok && (write_address == read_sel_1)) begin
      read_data_1 = write_data;
      read_busy_1 = 1'b0;
    end
    if ((bypass != 0) && write_ok && (write_address == read_sel_2)) begin
      read_data_2 = write_data;
      read_busy_2 = 1'b0;
    end

    if ((zero_reg != 0) && (read_sel_1 == '0)) begin
      read_data_1 = '0;
      read_busy_1 = 1'b0;
    end
    if ((zero_reg != 0) && (read_sel_2 == '0)) begin
      read_data_2 = '0;
      read_busy_2 = 1'b0;
    end
  end

  assign pending_any = |pending_bits;

endmodule

// File: tb/tb_param_register_file_sb.sv
// Directed bench for param_register_file_sb: reset pattern, bypass, zero register,
// scoreboard set/clear rules, mid-operation reset and a narrow parameter set.
`timescale 1ns/1ps
module tb_param_register_file_sb;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] write_data = '0;
  logic [4:0]  write_address = '0;
  logic        RegWrite = 1'b0;
  logic [4:0]  read_sel_1 = '0;
  logic [4:0]  read_sel_2 = '0;
  logic        busy_set = 1'b0;
  logic [4:0]  busy_address = '0;

  logic [31:0] m_rd1, m_rd2, nb_rd1, nb_rd2, nz_rd1, nz_rd2;
  logic        m_b1, m_b2, m_any, nb_b1, nb_b2, nb_any, nz_b1, nz_b2, nz_any;

  logic [7:0]  s_write_data = '0;
  logic [2:0]  s_write_address = '0;
  logic        s_regwrite = 1'b0;
  logic [2:0]  s_sel_1 = '0;
  logic [2:0]  s_sel_2 = '0;
  logic [7:0]  s_rd1, s_rd2;
  logic        s_b1, s_b2, s_any;

  int checks = 0;
  int errors = 0;

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  param_register_file_sb u_dut (
    .clk(clk), .rst_n(rst_n), .write_data(write_data), .write_address(write_address),
    .RegWrite(RegWrite), .read_sel_1(read_sel_1), .read_sel_2(read_sel_2),
    .read_data_1(m_rd1), .read_data_2(m_rd2), .busy_set(busy_set),
    .busy_address(busy_address), .read_busy_1(m_b1), .read_busy_2(m_b2),
    .pending_any(m_any));

  param_register_file_sb #(.bypass(0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .write_data(write_data), .write_address(write_address),
    .RegWrite(RegWrite), .read_sel_1(read_sel_1), .read_sel_2(read_sel_2),
    .read_data_1(nb_rd1), .read_data_2(nb_rd2), .busy_set(busy_set),
    .busy_address(busy_address), .read_busy_1(nb_b1), .read_busy_2(nb_b2),
    .pending_any(nb_any));

  param_register_file_sb #(.zero_reg(0)) u_nozero (
    .clk(clk), .rst_n(rst_n), .write_data(write_data), .write_address(write_address),
    .RegWrite(RegWrite), .read_sel_1(read_sel_1), .read_sel_2(read_sel_2),
    .read_data_1(nz_rd1), .read_data_2(nz_rd2), .busy_set(busy_set),
    .busy_address(busy_address), .read_busy_1(nz_b1), .read_busy_2(nz_b2),
    .pending_any(nz_any));

  param_register_file_sb #(.data_width(8), .select_width(3), .init_step(50)) u_small (
    .clk(clk), .rst_n(rst_n), .write_data(s_write_data), .write_address(s_write_address),
    .RegWrite(s_regwrite), .read_sel_1(s_sel_1), .read_sel_2(s_sel_2),
    .read_data_1(s_rd1), .read_data_2(s_rd2), .busy_set(1'b0),
    .busy_address(3'd0), .read_busy_1(s_b1), .read_busy_2(s_b2),
    .pending_any(s_any));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        bs;
    logic [4:0]  ba;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eb1;
    logic        eb2;
    logic        eany;
  } vec_t;

  vec_t vecs[15];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    RegWrite = 1'b0; busy_set = 1'b0; s_regwrite = 1'b0;
  endtask

  initial begin
    // Scoreboard walk on the default instance; expectations sampled before each edge.
    //          we  wa     wd            bs  ba     s1     s2     e1            e2          eb1   eb2   eany
    vecs[0]  = '{1'b0, 5'd0,  32'h0,     1'b1, 5'd7,  5'd7,  5'd3,  32'd70,     32'd30,     1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd7,  5'd7,  32'd70,     32'd70,     1'b1, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 5'd7,  32'h77,    1'b0, 5'd0,  5'd7,  5'd8,  32'h77,     32'd80,     1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd7,  5'd0,  32'h77,     32'd0,      1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 5'd9,  32'h99,    1'b1, 5'd9,  5'd9,  5'd9,  32'h99,     32'h99,     1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd9,  5'd9,  32'h99,     32'h99,     1'b1, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 5'd9,  32'h999,   1'b1, 5'd3,  5'd3,  5'd9,  32'd30,     32'h999,    1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd3,  5'd9,  32'd30,     32'h999,    1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,     1'b1, 5'd3,  5'd3,  5'd4,  32'd30,     32'd40,     1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 5'd4,  32'h44,    1'b0, 5'd0,  5'd4,  5'd3,  32'h44,     32'd30,     1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd4,  5'd3,  32'h44,     32'd30,     1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 5'd0,  32'h1234,  1'b1, 5'd12, 5'd0,  5'd12, 32'd0,      32'd120,    1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd0,  5'd12, 32'd0,      32'd120,    1'b0, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 5'd4,  32'hFFFF,  1'b0, 5'd0,  5'd4,  5'd31, 32'hFFFF,   32'd310,    1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd4,  5'd3,  32'hFFFF,   32'd30,     1'b0, 1'b1, 1'b1};

    // Reset with the clock stopped: outputs must show the init pattern combinationally.
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      read_sel_1 = 5'(i);
      read_sel_2 = 5'(31 - i);
      #1;
      check($sformatf("reset rd1 sel%0d", i), m_rd1, 32'(10 * i));
      check($sformatf("reset rd2 sel%0d", 31 - i), m_rd2, 32'(10 * (31 - i)));
      check($sformatf("reset busy sel%0d", i), {30'd0, m_b1, m_b2}, 32'd0);
    end
    check("reset pending_any", {31'd0, m_any}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      s_sel_1 = 3'(i);
      #1;
      check($sformatf("small reset sel%0d", i), {24'd0, s_rd1}, 32'((50 * i) % 256));
    end

    rst_n = 1'b1;
    #1 clk_en = 1'b1;
    next_cycle();

    for (int v = 0; v < 15; v++) begin
      RegWrite = vecs[v].we; write_address = vecs[v].wa; write_data = vecs[v].wd;
      busy_set = vecs[v].bs; busy_address = vecs[v].ba;
      read_sel_1 = vecs[v].s1; read_sel_2 = vecs[v].s2;
      #2;
      check($sformatf("vec%0d rd1", v), m_rd1, vecs[v].e1);
      check($sformatf("vec%0d rd2", v), m_rd2, vecs[v].e2);
      check($sformatf("vec%0d busy1", v), {31'd0, m_b1}, {31'd0, vecs[v].eb1});
      check($sformatf("vec%0d busy2", v), {31'd0, m_b2}, {31'd0, vecs[v].eb2});
      check($sformatf("vec%0d pending_any", v), {31'd0, m_any}, {31'd0, vecs[v].eany});
      next_cycle();
    end
    idle_inputs();

    // Mid-operation reset between edges: pending 3 and 12 set, register 4 = 0xFFFF.
    read_sel_1 = 5'd4; read_sel_2 = 5'd12;
    #1 rst_n = 1'b0;
    #1;
    check("midreset rd1 reg4", m_rd1, 32'd40);
    check("midreset rd2 reg12", m_rd2, 32'd120);
    check("midreset busy2", {31'd0, m_b2}, 32'd0);
    check("midreset pending_any", {31'd0, m_any}, 32'd0);
    rst_n = 1'b1;
    next_cycle();

    // Basic write: bypass vs. no bypass.
    RegWrite = 1'b1; write_address = 5'd5; write_data = 32'hDEADBEEF; read_sel_1 = 5'd5;
    #2;
    check("nobypass same-cycle rd", nb_rd1, 32'd50);
    check("bypass same-cycle rd", m_rd1, 32'hDEADBEEF);
    next_cycle();
    idle_inputs();
    #1;
    check("nobypass after edge rd", nb_rd1, 32'hDEADBEEF);
    check("bypass after edge rd", m_rd1, 32'hDEADBEEF);

    // Zero register with busy_set on address 0.
    RegWrite = 1'b1; write_address = 5'd0; write_data = 32'h1234;
    busy_set = 1'b1; busy_address = 5'd0; read_sel_1 = 5'd0; read_sel_2 = 5'd0;
    #2;
    check("zero same-cycle rd", m_rd1, 32'd0);
    check("nozero same-cycle rd", nz_rd1, 32'h1234);
    check("nozero same-cycle busy", {31'd0, nz_b1}, 32'd0);
    next_cycle();
    idle_inputs();
    #1;
    check("zero after edge rd", m_rd2, 32'd0);
    check("zero never pending", {31'd0, m_any}, 32'd0);
    check("nobypass zero rd", nb_rd1, 32'd0);
    check("nozero after edge rd", nz_rd2, 32'h1234);
    check("nozero set wins busy", {31'd0, nz_b1}, 32'd1);
    check("nozero pending_any", {31'd0, nz_any}, 32'd1);

    // Narrow instance: top address written and read on both ports.
    s_regwrite = 1'b1; s_write_address = 3'd7; s_write_data = 8'hA5; s_sel_1 = 3'd7; s_sel_2 = 3'd7;
    #2;
    check("small bypass rd1", {24'd0, s_rd1}, 32'h0A5);
    check("small bypass rd2", {24'd0, s_rd2}, 32'h0A5);
    next_cycle();
    idle_inputs();
    #1;
    check("small rd1 addr7", {24'd0, s_rd1}, 32'h0A5);
    check("small rd2 addr7", {24'd0, s_rd2}, 32'h0A5);
    s_sel_1 = 3'd6;
    #1;
    check("small reg6 untouched", {24'd0, s_rd1}, 32'd44);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
